// File: rtl/led_blink_multi_if.sv
// Control and status bundle for the multi-channel LED blinker.
// The master side drives enables and codes; the slave side returns LED state.
interface led_blink_multi_if #(
    parameter int N_CH = 4
);
    logic              i_enable;
    logic [N_CH-1:0]   i_ch_enable;
    logic [2*N_CH-1:0] i_sel;
    logic [N_CH-1:0]   o_led_drive;
    logic [2*N_CH-1:0] o_sel_active;
    logic [N_CH-1:0]   o_phase_done;

    modport master (
        output i_enable, i_ch_enable, i_sel,
        input  o_led_drive, o_sel_active, o_phase_done
    );

    modport slave (
        input  i_enable, i_ch_enable, i_sel,
        output o_led_drive, o_sel_active, o_phase_done
    );
endinterface

// File: rtl/led_blink_multi.sv
// N-channel LED blinker: each channel counts its own half-periods from a
// 4-entry frequency table and adopts a new code only at a falling toggle.
module led_blink_multi #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int N_CH        = 4,
    parameter int FREQ0_HZ    = 100,
    parameter int FREQ1_HZ    = 50,
    parameter int FREQ2_HZ    = 10,
    parameter int FREQ3_HZ    = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    led_blink_multi_if.slave  bus
);
    localparam int H0 = CLK_FREQ_HZ / (2 * FREQ0_HZ);
    localparam int H1 = CLK_FREQ_HZ / (2 * FREQ1_HZ);
    localparam int H2 = CLK_FREQ_HZ / (2 * FREQ2_HZ);
    localparam int H3 = CLK_FREQ_HZ / (2 * FREQ3_HZ);

    localparam int H_MAX01 = (H0 > H1) ? H0 : H1;
    localparam int H_MAX23 = (H2 > H3) ? H2 : H3;
    localparam int H_MAX   = (H_MAX01 > H_MAX23) ? H_MAX01 : H_MAX23;
    // cnt holds at most H-1, so clog2(H_MAX) bits suffice.
    localparam int CNT_W   = (H_MAX > 1) ? $clog2(H_MAX) : 1;

    if (H0 < 1 || H1 < 1 || H2 < 1 || H3 < 1) begin : g_bad_freq
        $error("led_blink_multi: every half-period must be at least one clock cycle");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("led_blink_multi: N_CH must be in 1..16");
    end

    function automatic logic [CNT_W-1:0] reload(input logic [1:0] code);
        int h;
        case (code)
            2'd0:    h = H0;
            2'd1:    h = H1;
            2'd2:    h = H2;
            default: h = H3;
        endcase
        return CNT_W'(h - 1);
    endfunction

    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   led;
    logic [2*N_CH-1:0] sel_act;
    logic [N_CH-1:0]   phase_done;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            // NOTE: the counter array lives in flops, not RAM, so it can and must be cleared with everything else.
            for (int c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
            end
            led        <= '0;
            sel_act    <= '0;
            phase_done <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                // NOTE: non-blocking only: each decision below must see pre-edge state.
                phase_done[c] <= 1'b0;
                if (!(bus.i_enable && bus.i_ch_enable[c])) begin
                    cnt[c]            <= '0;
                    led[c]            <= 1'b0;
                    sel_act[2*c +: 2] <= bus.i_sel[2*c +: 2];
                end else if (cnt[c] != '0) begin
                    cnt[c] <= cnt[c] - CNT_W'(1);
                end else if (!led[c]) begin
                    led[c] <= 1'b1;
                    cnt[c] <= reload(sel_act[2*c +: 2]);
                end else begin
                    // Falling toggle: the only point where a new code is adopted.
                    led[c]            <= 1'b0;
                    sel_act[2*c +: 2] <= bus.i_sel[2*c +: 2];
                    cnt[c]            <= reload(bus.i_sel[2*c +: 2]);
                    phase_done[c]     <= 1'b1;
                end
            end
        end
    end

    assign bus.o_led_drive  = led;
    assign bus.o_sel_active = sel_act;
    assign bus.o_phase_done = phase_done;
endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi with H = 2/4/10/20 cycles; expected
// outputs are queued per clock and compared 1 time unit after the edge.
module tb_led_blink_multi;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_blink_multi_if #(.N_CH(4)) bus ();

    led_blink_multi #(
        .CLK_FREQ_HZ (200),
        .N_CH        (4),
        .FREQ0_HZ    (50),
        .FREQ1_HZ    (25),
        .FREQ2_HZ    (10),
        .FREQ3_HZ    (5)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic [3:0] pd;
        logic [7:0] sa;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic led_at(int n, int h);
        return (n % (2 * h)) < h;
    endfunction

    function automatic logic pd_at(int n, int h);
        return (n % (2 * h)) == h;
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge outputs, clock once, then pop and compare.
    task automatic cycle(string tag, logic [3:0] led, logic [3:0] pd, logic [7:0] sa);
        exp_t e;
        e.tag = tag;
        e.led = led;
        e.pd  = pd;
        e.sa  = sa;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, "/led"}, {4'h0, bus.o_led_drive},  {4'h0, e.led});
        check({e.tag, "/pd"},  {4'h0, bus.o_phase_done}, {4'h0, e.pd});
        check({e.tag, "/sa"},  bus.o_sel_active,         e.sa);
    endtask

    initial begin
        logic l1, l3, p1, p3, l, p;
        int m;

        // Reset held with every input high.
        rst_n           = 1'b0;
        bus.i_enable    = 1'b1;
        bus.i_ch_enable = 4'hF;
        bus.i_sel       = 8'hFF;
        for (int n = 0; n < 3; n++) begin
            cycle($sformatf("reset n=%0d", n), 4'h0, 4'h0, 8'h00);
        end

        // Release with code 00 everywhere: 2 high / 2 low from the first edge.
        bus.i_sel = 8'h00;
        rst_n     = 1'b1;
        for (int n = 0; n < 12; n++) begin
            l = led_at(n, 2);
            p = pd_at(n, 2);
            cycle($sformatf("pwrup n=%0d", n), {4{l}}, {4{p}}, 8'h00);
        end

        // Ch1 code 01, ch3 code 11, enabled together after a disable cycle.
        bus.i_ch_enable = 4'h0;
        bus.i_sel       = 8'hC4;
        cycle("pair_dis", 4'h0, 4'h0, 8'hC4);
        bus.i_ch_enable = 4'b1010;
        for (int n = 0; n < 80; n++) begin
            l1 = led_at(n, 4);
            l3 = led_at(n, 20);
            p1 = pd_at(n, 4);
            p3 = pd_at(n, 20);
            cycle($sformatf("pair n=%0d", n), {l3, 1'b0, l1, 1'b0}, {p3, 1'b0, p1, 1'b0}, 8'hC4);
        end

        // Ch2 code 11 switched to 00 in its 3rd high cycle, then a transient
        // code 10 applied and removed while low.
        bus.i_ch_enable = 4'h0;
        bus.i_sel       = 8'h30;
        cycle("chg_dis", 4'h0, 4'h0, 8'h30);
        bus.i_ch_enable = 4'b0100;
        for (int n = 0; n < 44; n++) begin
            if (n < 20) begin
                cycle($sformatf("chg n=%0d", n), 4'b0100, 4'h0, 8'h30);
            end else begin
                m = n - 20;
                l = (m % 4) >= 2;
                p = (m % 4) == 0;
                cycle($sformatf("chg n=%0d", n), {1'b0, l, 2'b00}, {1'b0, p, 2'b00}, 8'h00);
            end
            if (n == 2)  bus.i_sel = 8'h00;
            if (n == 32) bus.i_sel = 8'h20;
            if (n == 34) bus.i_sel = 8'h00;
        end

        // Global enable dropped for one cycle mid-high, then re-enabled.
        bus.i_ch_enable = 4'h0;
        bus.i_sel       = 8'h55;
        cycle("en_dis", 4'h0, 4'h0, 8'h55);
        bus.i_ch_enable = 4'hF;
        cycle("en_pre n=0", 4'hF, 4'h0, 8'h55);
        cycle("en_pre n=1", 4'hF, 4'h0, 8'h55);
        bus.i_enable = 1'b0;
        cycle("en_drop", 4'h0, 4'h0, 8'h55);
        bus.i_enable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            l = led_at(n, 4);
            p = pd_at(n, 4);
            cycle($sformatf("en_re n=%0d", n), {4{l}}, {4{p}}, 8'h55);
        end

        // One-cycle reset pulse mid-high. The first high phase runs on the
        // cleared code 00; the code 01 on i_sel is adopted at the first fall.
        rst_n = 1'b0;
        cycle("rst_pulse", 4'h0, 4'h0, 8'h00);
        rst_n = 1'b1;
        for (int n = 0; n < 18; n++) begin
            if (n < 2) begin
                cycle($sformatf("rst_re n=%0d", n), 4'hF, 4'h0, 8'h00);
            end else begin
                m = n - 2;
                l = (m % 8) >= 4;
                p = (m % 8) == 0;
                cycle($sformatf("rst_re n=%0d", n), {4{l}}, {4{p}}, 8'h55);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
